// File: rtl/muskbus_writer_if.sv
// rtl/muskbus_writer_if.sv - Muskbus tag package and bus interface
package MUSKBUS;
    localparam int              TAG_W         = 13;
    localparam logic [TAG_W-1:0] WRITE_MEM_TAG = 13'h1401;
endpackage

interface Muskbus;
    logic                      bid;
    logic                      reqcyc;
    logic [MUSKBUS::TAG_W-1:0] reqtag;
    logic [63:0]               req;
    logic                      reqack;
    logic                      respack;
    logic                      respcyc;
    logic [63:0]               resp;

    modport Top (
        output bid, reqcyc, reqtag, req, respack,
        input  reqack, respcyc, resp
    );
endinterface

// File: rtl/muskbus_writer.sv
// rtl/muskbus_writer.sv - Muskbus write master: one address beat then BEATS data beats per line
module muskbus_writer #(
    parameter int BEATS = 8
) (
    input  logic                clk,
    input  logic                reset,
    Muskbus.Top                 bus,
    input  logic                reqcyc,
    input  logic [63:0]         addr,
    input  logic [0:64*BEATS-1] data,
    output logic                ready,
    output logic                respcyc
);
    localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [63:0]         addr_ff;
    logic [0:64*BEATS-1] buf_ff;
    logic [BW-1:0]       beat_ff;

    logic                w_capture;
    logic                w_advance;
    logic [BW+5:0]       w_beat_base;
    logic [63:0]         w_beat_data;

    // Responses are never consumed; keep the sampled-but-unused bus inputs visible.
    wire w_unused_bus = &{1'b0, bus.respcyc, bus.resp};

    // Beat 0 sits at the most-significant end of the line (lowest ascending index).
    assign w_beat_base = {beat_ff, 6'd0};
    assign w_beat_data = buf_ff[w_beat_base +: 64];

    // State register; reset abandons any line in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Line capture and beat counter; the counter stops at the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_ff <= '0;
            buf_ff  <= '0;
            beat_ff <= '0;
        end else if (w_capture) begin
            addr_ff <= {addr[63:6], 6'd0};
            buf_ff  <= data;
            beat_ff <= '0;
        end else if (w_advance) begin
            beat_ff <= beat_ff + 1'b1;
        end
    end

    // Next-state and output decode; outputs depend on registered state only.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        ready        = 1'b0;
        respcyc      = 1'b0;
        bus.bid      = 1'b0;
        bus.reqcyc   = 1'b0;
        bus.req      = '0;
        bus.reqtag   = MUSKBUS::WRITE_MEM_TAG;
        bus.respack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (reqcyc) begin
                    w_capture    = 1'b1;
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.bid    = 1'b1;
                bus.reqcyc = 1'b1;
                bus.req    = addr_ff;
                if (bus.reqack) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                bus.bid    = 1'b1;
                bus.reqcyc = 1'b1;
                bus.req    = w_beat_data;
                if (bus.reqack) begin
                    if (beat_ff == LAST_BEAT) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_DONE: begin
                respcyc      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end
endmodule
